// File: rtl/mdio_arb.sv
// mdio_arb: round-robin arbiter between software MMFR frames and a periodic BMSR link poller
// sharing one MDIO interface. The poller is compiled in only when MDIO_ARB_POLL_EN is defined.
module mdio_arb #(
  parameter logic [23:0] POLL_DIV = 24'd1000000,
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [3:0]  LINK_BIT = 4'd2,
  parameter logic [15:0] TIMEOUT  = 16'd65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_rst,
  input  logic        sw_req,
  input  logic [31:0] sw_frame,
  output logic        sw_ack,
  output logic        sw_done,
  output logic        sw_err,
  output logic [15:0] sw_rdata,
  output logic        mmfr_wen,
  output logic        eir_wen,
  output logic [31:0] reg_wdata,
  input  logic        mii,
  input  logic [31:0] mmfr,
  output logic        link_up,
  output logic        link_chg
);

  localparam logic [31:0] POLL_FRAME = 32'h6002_0000 | ({27'd0, PHY_ADDR} << 5'd23) | (32'd1 << 5'd18);
  localparam logic [31:0] EIR_MII    = 32'h0080_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic        gnt_poll_r, gnt_poll_nx_s;
  logic [15:0] wait_cnt_r;
  logic        grant_s, done_s, timeout_s;
  logic        poll_pend_s, last_poll_s;
  logic        sw_ack_r, sw_done_r, sw_err_r, mmfr_wen_r, eir_wen_r;
  logic [15:0] sw_rdata_r;
  logic [31:0] reg_wdata_r;
  logic        unused_s;

  assign unused_s = ^{mmfr, POLL_DIV, LINK_BIT};

  // Next-state: arbitration in IDLE, completion/timeout detection in WAIT
  always_comb begin
    state_nx_s    = state_r;
    gnt_poll_nx_s = gnt_poll_r;
    done_s        = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sw_req || poll_pend_s) begin
          state_nx_s    = S_ISSUE;
          gnt_poll_nx_s = poll_pend_s && (!sw_req || !last_poll_s);
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ISSUE: state_nx_s = S_WAIT;
      S_WAIT: begin
        if (mii) begin
          done_s     = 1'b1;
          state_nx_s = S_CLEAR;
        end else if (wait_cnt_r == TIMEOUT - 16'd1) begin
          done_s     = 1'b1;
          timeout_s  = 1'b1;
          state_nx_s = S_CLEAR;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_CLEAR: state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  assign grant_s = (state_r == S_IDLE) && (state_nx_s == S_ISSUE);

  // FSM state, WAIT counter and registered outputs (ISSUE/CLEAR strobes land in those states)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      gnt_poll_r  <= 1'b0;
      wait_cnt_r  <= 16'd0;
      sw_ack_r    <= 1'b0;
      sw_done_r   <= 1'b0;
      sw_err_r    <= 1'b0;
      sw_rdata_r  <= 16'd0;
      mmfr_wen_r  <= 1'b0;
      eir_wen_r   <= 1'b0;
      reg_wdata_r <= 32'd0;
    end else if (sync_rst) begin
      state_r     <= S_IDLE;
      gnt_poll_r  <= 1'b0;
      wait_cnt_r  <= 16'd0;
      sw_ack_r    <= 1'b0;
      sw_done_r   <= 1'b0;
      sw_err_r    <= 1'b0;
      sw_rdata_r  <= 16'd0;
      mmfr_wen_r  <= 1'b0;
      eir_wen_r   <= 1'b0;
      reg_wdata_r <= 32'd0;
    end else begin
      state_r    <= state_nx_s;
      gnt_poll_r <= gnt_poll_nx_s;
      wait_cnt_r <= (state_r == S_WAIT) ? wait_cnt_r + 16'd1 : 16'd0;
      mmfr_wen_r <= grant_s;
      sw_ack_r   <= grant_s && !gnt_poll_nx_s;
      eir_wen_r  <= done_s;
      sw_done_r  <= done_s && !gnt_poll_r;
      sw_err_r   <= done_s && !gnt_poll_r && timeout_s;
      if (done_s && !gnt_poll_r && !timeout_s) begin
        sw_rdata_r <= mmfr[15:0];
      end
      if (grant_s) begin
        reg_wdata_r <= gnt_poll_nx_s ? POLL_FRAME : sw_frame;
      end else if (done_s) begin
        reg_wdata_r <= EIR_MII;
      end else begin
        reg_wdata_r <= 32'd0;
      end
    end
  end

`ifdef MDIO_ARB_POLL_EN
  logic [23:0] poll_cnt_r;
  logic        poll_pend_r, last_poll_r, link_up_r, link_chg_r, poll_wrap_s;

  assign poll_wrap_s = (poll_cnt_r == POLL_DIV - 24'd1);

  // Poll tick, pending flag and link status; a wrap on the grant cycle re-arms the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt_r  <= 24'd0;
      poll_pend_r <= 1'b0;
      last_poll_r <= 1'b1;
      link_up_r   <= 1'b0;
      link_chg_r  <= 1'b0;
    end else if (sync_rst) begin
      poll_cnt_r  <= 24'd0;
      poll_pend_r <= 1'b0;
      last_poll_r <= 1'b1;
      link_up_r   <= 1'b0;
      link_chg_r  <= 1'b0;
    end else begin
      poll_cnt_r <= poll_wrap_s ? 24'd0 : poll_cnt_r + 24'd1;
      if (poll_wrap_s) begin
        poll_pend_r <= 1'b1;
      end else if (grant_s && gnt_poll_nx_s) begin
        poll_pend_r <= 1'b0;
      end
      if (grant_s) begin
        last_poll_r <= gnt_poll_nx_s;
      end
      if (done_s && gnt_poll_r && !timeout_s) begin
        link_up_r  <= mmfr[{1'b0, LINK_BIT}];
        link_chg_r <= mmfr[{1'b0, LINK_BIT}] ^ link_up_r;
      end else begin
        link_chg_r <= 1'b0;
      end
    end
  end

  assign poll_pend_s = poll_pend_r;
  assign last_poll_s = last_poll_r;
  assign link_up     = link_up_r;
  assign link_chg    = link_chg_r;
`else
  assign poll_pend_s = 1'b0;
  assign last_poll_s = 1'b1;
  assign link_up     = 1'b0;
  assign link_chg    = 1'b0;
`endif

  assign sw_ack    = sw_ack_r;
  assign sw_done   = sw_done_r;
  assign sw_err    = sw_err_r;
  assign sw_rdata  = sw_rdata_r;
  assign mmfr_wen  = mmfr_wen_r;
  assign eir_wen   = eir_wen_r;
  assign reg_wdata = reg_wdata_r;

endmodule

// File: tb/tb_mdio_arb.sv
// Scoreboard bench for mdio_arb: stimulus queues expected frames/completions, a PHY responder
// model drives mii/mmfr, and a negedge monitor performs every comparison.
module tb_mdio_arb;

  localparam logic [31:0] POLL_FRAME = 32'h6186_0000;
  localparam logic [31:0] EIR_CLR    = 32'h0080_0000;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_rst = 1'b0;
  logic        sw_req = 1'b0;
  logic [31:0] sw_frame = 32'd0;
  logic        mii = 1'b0;
  logic [31:0] mmfr = 32'd0;
  logic        sw_ack, sw_done, sw_err, mmfr_wen, eir_wen, link_up, link_chg;
  logic [15:0] sw_rdata;
  logic [31:0] reg_wdata;

  logic [31:0] exp_issue[$];
  done_t       exp_done[$];

  int          resp_delay = 20;
  logic [15:0] resp_data = 16'd0;
  logic        poll_status = 1'b0;
  int          timeouts = 0;
  logic        do_final = 1'b0;
  int          held_mark = 0;
  int          held_end = 0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          chg_cnt = 0;
  string       glog = "";
  logic        cur_poll = 1'b0;
  logic        link_model = 1'b0;
  logic        post_rst = 1'b0;
  logic        final_done = 1'b0;

  always #5 clk = ~clk;

  mdio_arb #(
    .POLL_DIV(24'd100),
    .PHY_ADDR(5'd3),
    .LINK_BIT(4'd2),
    .TIMEOUT (16'd50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_rst (sync_rst),
    .sw_req   (sw_req),
    .sw_frame (sw_frame),
    .sw_ack   (sw_ack),
    .sw_done  (sw_done),
    .sw_err   (sw_err),
    .sw_rdata (sw_rdata),
    .mmfr_wen (mmfr_wen),
    .eir_wen  (eir_wen),
    .reg_wdata(reg_wdata),
    .mii      (mii),
    .mmfr     (mmfr),
    .link_up  (link_up),
    .link_chg (link_chg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // PHY model: raises mii resp_delay cycles after a software issue (never if 0), 3 after a poll
  initial begin
    int   rcnt;
    logic rpoll;
    rcnt  = 0;
    rpoll = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || sync_rst) begin
        rcnt = 0;
        mii  = 1'b0;
      end else begin
        if (eir_wen) mii = 1'b0;
        if (mmfr_wen) begin
          rpoll = !sw_ack;
          rcnt  = sw_ack ? resp_delay : 3;
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            mii  = 1'b1;
            mmfr = rpoll ? {29'd0, poll_status, 2'b00} : {16'd0, resp_data};
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT strobe and checks the idle/reset behaviour
  initial begin
    done_t e;
    int    npoll, npp;
    forever begin
      @(negedge clk);
      cyc++;
      if (post_rst) begin
        chk("sync_rst_outputs", {sw_ack, sw_done, sw_err, mmfr_wen, eir_wen, link_up, link_chg, sw_rdata, reg_wdata}, 64'd0);
        post_rst = 1'b0;
      end
      if (!rst_n) begin
        chk("rst_outputs", {sw_ack, sw_done, sw_err, mmfr_wen, eir_wen, link_up, link_chg, sw_rdata, reg_wdata}, 64'd0);
        cur_poll   = 1'b0;
        link_model = 1'b0;
      end else if (sync_rst) begin
        post_rst   = 1'b1;
        cur_poll   = 1'b0;
        link_model = 1'b0;
      end else begin
        if (link_chg) chg_cnt++;
`ifndef MDIO_ARB_POLL_EN
        chk("link_tied_low", {link_up, link_chg}, 64'd0);
`endif
        if (mmfr_wen) begin
          chk("wen_exclusive", eir_wen, 64'd0);
`ifndef MDIO_ARB_POLL_EN
          chk("issue_is_sw", sw_ack, 64'd1);
`endif
          if (sw_ack) begin
            ack_cyc  = cyc;
            glog     = {glog, "s"};
            cur_poll = 1'b0;
            chk("sw_issue_expected", exp_issue.size() != 0, 64'd1);
            if (exp_issue.size() != 0) chk("sw_frame_out", reg_wdata, exp_issue.pop_front());
          end else begin
            glog     = {glog, "p"};
            cur_poll = 1'b1;
            chk("poll_frame", reg_wdata, POLL_FRAME);
          end
        end else begin
          chk("ack_only_with_wen", sw_ack, 64'd0);
        end
        if (eir_wen) begin
          chk("eir_wdata", reg_wdata, EIR_CLR);
          if (cur_poll) begin
            chk("poll_link_chg", link_chg, link_model != mmfr[2]);
            link_model = mmfr[2];
            chk("poll_link_up", link_up, link_model);
            chk("poll_no_sw_done", sw_done, 64'd0);
          end else begin
            chk("sw_done_at_clear", sw_done, 64'd1);
            chk("sw_no_link_chg", link_chg, 64'd0);
          end
          cur_poll = 1'b0;
        end else begin
          chk("quiet_outside_clear", {sw_done, link_chg}, 64'd0);
        end
        if (!mmfr_wen && !eir_wen) chk("idle_wdata", reg_wdata, 64'd0);
        if (sw_done) begin
          chk("sw_done_expected", exp_done.size() != 0, 64'd1);
          if (exp_done.size() != 0) begin
            e = exp_done.pop_front();
            chk("sw_err", sw_err, e.err);
            chk("sw_rdata", sw_rdata, e.rdata);
            chk("ack_to_done_cycles", cyc - ack_cyc, e.lat);
          end
        end
      end
      if (do_final && !final_done) begin
        chk("wait_bounds", timeouts, 64'd0);
        chk("done_queue_drained", exp_done.size(), 64'd0);
`ifdef MDIO_ARB_POLL_EN
        npoll = 0;
        npp   = 0;
        for (int i = held_mark; i < held_end; i++) begin
          if (glog[i] == "p") npoll++;
          if (i + 1 < held_end && glog[i] == "p" && glog[i+1] == "p") npp++;
        end
        chk("rr_polls_between_sw", npoll >= 2, 64'd1);
        chk("rr_no_back_to_back_poll", npp, 64'd0);
        chk("link_chg_pulses", chg_cnt, 64'd1);
        chk("link_up_final", link_up, 64'd1);
`else
        chk("link_up_final", link_up, 64'd0);
`endif
        final_done = 1'b1;
      end
    end
  end

  task automatic wait_ack();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (sw_ack) return;
    end
    timeouts++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (sw_done) return;
    end
    timeouts++;
  endtask

  task automatic sw_txn(input logic [31:0] f, input int d, input logic [15:0] data,
                        input logic exp_err, input logic [15:0] exp_rd, input int exp_lat,
                        input bit keep_req);
    resp_delay = d;
    resp_data  = data;
    exp_issue.push_back(f);
    exp_done.push_back('{exp_err, exp_rd, exp_lat});
    sw_frame = f;
    sw_req   = 1'b1;
    wait_ack();
    if (!keep_req) sw_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // read: mii 20 cycles after ISSUE, data 1234
    sw_txn(32'h6086_0000, 20, 16'h1234, 1'b0, 16'h1234, 21, 1'b0);
    wait_done();
    // write frame passes through unchanged
    sw_txn(32'h5086_ABCD, 5, 16'hABCD, 1'b0, 16'hABCD, 6, 1'b0);
    wait_done();
    // no response: timeout after 50 WAIT cycles, rdata keeps ABCD
    sw_txn(32'h6086_0000, 0, 16'hFFFF, 1'b1, 16'hABCD, 51, 1'b0);
    wait_done();
    // soft reset while waiting: aborted silently
    resp_delay = 0;
    exp_issue.push_back(32'h6086_0000);
    sw_frame = 32'h6086_0000;
    sw_req   = 1'b1;
    wait_ack();
    sw_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 sync_rst = 1'b1;
    @(posedge clk);
    #1 sync_rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    sw_txn(32'h6086_0000, 10, 16'h5A5A, 1'b0, 16'h5A5A, 11, 1'b0);
    wait_done();
    // software request held across six transactions
    held_mark = glog.len();
    for (int i = 0; i < 6; i++) sw_txn(32'h6086_0000, 45, 16'h00C3, 1'b0, 16'h00C3, 46, i < 5);
    wait_done();
    held_end = glog.len();
    // link comes up: one change pulse, later polls silent
    poll_status = 1'b1;
    repeat (250) @(posedge clk);
    #1 do_final = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_arb.md
MDIO_ARB -- requirements
Module: mdio_arb

Interface
REQ-001 SHALL have parameter POLL_DIV, default 24'd1000000, poller tick period in clk cycles (legal range 2..2^24-1).
REQ-002 SHALL have parameter PHY_ADDR, default 5'd0, PHY address used by the poller.
REQ-003 SHALL have parameter LINK_BIT, default 4'd2, bit of the polled register (BMSR, reg 1) that reports link status.
REQ-004 SHALL have parameter TIMEOUT, default 16'd65535, maximum number of clk cycles spent in WAIT.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sync_rst  input  1  synchronous soft reset, same effect as rst_n.
REQ-008 sw_req  input  1  software frame request, level, held until sw_ack.
REQ-009 sw_frame  input  32  MMFR-format frame: [31:30] ST, [29:28] OP (10 rd, 01 wr), [27:23] PA, [22:18] RA, [17:16] TA, [15:0] data.
REQ-010 sw_ack  output  1  one-cycle pulse when sw_frame is issued.
REQ-011 sw_done  output  1  one-cycle pulse when the software transaction ends.
REQ-012 sw_err  output  1  valid with sw_done; 1 = timeout.
REQ-013 sw_rdata  output  16  mmfr[15:0] captured at completion, held until the next software completion.
REQ-014 mmfr_wen, eir_wen  output  1 each  write strobes toward the MDIO interface.
REQ-015 reg_wdata  output  32  write data toward the MDIO interface.
REQ-016 mii  input  1  MDIO interface completion flag (sticky until cleared via EIR bit 23).
REQ-017 mmfr  input  32  MDIO interface frame/read-data register.
REQ-018 link_up  output  1  last polled link status; link_chg  output  1  one-cycle pulse when link_up changes.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> CLEAR -> IDLE, one state per cycle except WAIT.
REQ-020 IDLE: if a requester is pending, grant it and go to ISSUE next cycle; else stay.
REQ-021 Arbitration SHALL be round-robin: if both are pending, the requester not granted last wins; after reset, software wins.
REQ-022 ISSUE: mmfr_wen=1 for exactly one cycle with reg_wdata = granted frame; sw_ack pulses in the same cycle if software is granted.
REQ-023 Poller frame SHALL be 32'h6002_0000 | PHY_ADDR<<23 | 5'd1<<18.
REQ-024 WAIT: leave when mii=1 (normal) or when the WAIT cycle count reaches TIMEOUT (error); the counter resets on WAIT entry.
REQ-025 CLEAR: eir_wen=1 for exactly one cycle with reg_wdata=32'h0080_0000, always, including after a timeout.
REQ-026 mmfr_wen and eir_wen SHALL never be asserted in the same cycle; reg_wdata=0 when neither is asserted.
REQ-027 On a software completion, sw_done pulses in the CLEAR cycle; sw_rdata=mmfr[15:0] when normal, unchanged when the transaction timed out; sw_err=timeout.
REQ-028 On a poller completion, link_up<=mmfr[LINK_BIT] in the CLEAR cycle; link_chg pulses in the same cycle if the value differs; on timeout, link_up is unchanged and no pulse is given.
REQ-029 Poll counter SHALL count 0..POLL_DIV-1 and wrap, setting poll_pend at the wrap.
REQ-030 poll_pend SHALL be cleared on grant; a wrap while poll_pend=1 is dropped (no queueing).
REQ-031 A wrap in the same cycle as the poller grant SHALL leave poll_pend=1.
REQ-032 sw_req deasserted before sw_ack SHALL withdraw the request without side effects.

Reset
REQ-033 On rst_n=0 or sync_rst=1: FSM=IDLE, counters=0, poll_pend=0, last-grant=poller, all outputs 0.
REQ-034 Reset mid-transaction SHALL abort it without any sw_done, eir_wen or link_chg pulse.

Configuration
REQ-035 Macro MDIO_ARB_POLL_EN: when defined, the poller and round-robin logic are compiled in. When undefined, the poller logic is absent, only software is arbitrated, and link_up and link_chg are tied to 0.

Verification
REQ-036 sw_req with frame 32'h6086_0000, mii rises 20 cycles after ISSUE, mmfr[15:0]=16'h1234 -> sw_ack at ISSUE, eir_wen with 32'h0080_0000, sw_done, sw_err=0, sw_rdata=16'h1234.
REQ-037 Write frame 32'h5086_ABCD -> one mmfr_wen cycle with reg_wdata=32'h5086_ABCD; sw_done after mii rises.
REQ-038 POLL_DIV=100, PHY_ADDR=3, mmfr[2]=1 -> poll frame 32'h6186_0000; link_up goes 0->1 with one link_chg pulse; a second poll with the same status gives no pulse.
REQ-039 sw_req held continuously while poll_pend=1 -> grants alternate sw, poll, sw.
REQ-040 TIMEOUT=50, mii held 0 -> sw_done with sw_err=1 after 50 WAIT cycles, eir_wen still pulsed, sw_rdata unchanged.
REQ-041 sync_rst asserted in WAIT -> IDLE next cycle, no sw_done or eir_wen; a new sw_req is then served normally.
